// File: rtl/datapath_ctrl_if.sv
// ---------------------------------------------------------------------------
// datapath_ctrl_if
//   Groups the instruction and result handshakes of the datapath sequencer.
//
//   Parameters
//     WIDTH    datapath word width
//     CNT_W    repeat-count field width
//     INSTR_W  derived instruction width, 4 + CNT_W + WIDTH
//
//   Signals
//     instr_valid  producer -> sequencer  instruction present
//     instr_ready  sequencer -> producer  sequencer can accept
//     instr        producer -> sequencer  {op, alu_sel, cnt, imm}
//     res_valid    sequencer -> consumer  result available
//     res_ready    consumer -> sequencer  consumer can take the result
//     res_data     sequencer -> consumer  captured register value
//     res_carry    sequencer -> consumer  carry flag at capture
//
//   Modports
//     master  the side that issues instructions and collects results
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface datapath_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);

    localparam int INSTR_W = 4 + CNT_W + WIDTH;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_data;
    logic               res_carry;

    modport master (
        output instr_valid,
        output instr,
        output res_ready,
        input  instr_ready,
        input  res_valid,
        input  res_data,
        input  res_carry
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  res_ready,
        output instr_ready,
        output res_valid,
        output res_data,
        output res_carry
    );

endinterface

// File: rtl/datapath_ctrl.sv
// ---------------------------------------------------------------------------
// datapath_ctrl
//   Instruction sequencer sitting directly upstream of a small datapath
//   (register, input mux, ALU). Each accepted instruction is decoded into
//   one or more datapath writeback cycles, or into a result transfer that
//   returns the register contents together with the last ALU carry.
//
//   Instruction word: {op[1:0], alu_sel[1:0], cnt[CNT_W-1:0], imm[WIDTH-1:0]}
//     op 00 LOAD    reg <= imm
//     op 01 EXEC    reg <= ALU(reg, imm, alu_sel), once (cnt ignored)
//     op 10 REPEAT  as EXEC, cnt+1 consecutive cycles
//     op 11 READ    emit reg and carry flag on the result port
//
//   Ports
//     clk          clock, all state on the rising edge
//     rst_n        synchronous reset, active low
//     bus          instruction / result handshakes (slave modport)
//     dp_mux_sel   datapath mux select: 0 = external operand, 1 = ALU result
//     dp_load      datapath register load enable
//     dp_alu_sel   datapath ALU operation select
//     dp_mux_data  datapath mux external operand
//     dp_alu_data  datapath ALU B operand
//     dp_reg_out   datapath register value
//     dp_carry     datapath ALU carry out
//
//   The interface instance must be built with the same WIDTH and CNT_W.
// ---------------------------------------------------------------------------
module datapath_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    datapath_ctrl_if.slave     bus,
    output logic               dp_mux_sel,
    output logic               dp_load,
    output logic [1:0]         dp_alu_sel,
    output logic [WIDTH-1:0]   dp_mux_data,
    output logic [WIDTH-1:0]   dp_alu_data,
    input  logic [WIDTH-1:0]   dp_reg_out,
    input  logic               dp_carry
);

    localparam int INSTR_W = 4 + CNT_W + WIDTH;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_EXEC   = 2'b01,
        OP_REPEAT = 2'b10,
        OP_READ   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WB_LOAD = 2'b01,
        WB_ALU  = 2'b10,
        EMIT    = 2'b11
    } state_e;

    state_e             state;
    state_e             next_state;

    // Fields of the incoming instruction word
    op_e                in_op;
    logic [1:0]         in_alu_sel;
    logic [CNT_W-1:0]   in_cnt;
    logic [WIDTH-1:0]   in_imm;

    // Latched instruction operands; the opcode itself is carried by the state
    logic [1:0]         alu_sel_q;
    logic [WIDTH-1:0]   imm_q;
    logic [CNT_W-1:0]   remaining;

    logic               carry_flag;
    logic [WIDTH-1:0]   res_data_q;
    logic               res_carry_q;

    logic               accept;

    // Slice the instruction word into its fields.
    always_comb begin
        in_op      = op_e'(bus.instr[INSTR_W-1 -: 2]);
        in_alu_sel = bus.instr[INSTR_W-3 -: 2];
        in_cnt     = bus.instr[WIDTH +: CNT_W];
        in_imm     = bus.instr[WIDTH-1:0];
    end

    assign accept = bus.instr_valid & bus.instr_ready;

    // State register. Reset mid-operation simply drops back to IDLE, so
    // whatever iterations a REPEAT still had left are discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Every output defaults to zero so states
    // that do not use an operand present 0 on it. dp_load, instr_ready and
    // res_valid are additionally gated with rst_n so that a reset cycle can
    // never write the datapath register or complete a handshake, whatever
    // state the register happens to hold.
    always_comb begin
        next_state      = state;
        dp_mux_sel      = 1'b0;
        dp_load         = 1'b0;
        dp_alu_sel      = 2'b00;
        dp_mux_data     = '0;
        dp_alu_data     = '0;
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;

        case (state)
            IDLE: begin
                bus.instr_ready = rst_n;
                if (accept) begin
                    case (in_op)
                        OP_LOAD:   next_state = WB_LOAD;
                        OP_EXEC:   next_state = WB_ALU;
                        OP_REPEAT: next_state = WB_ALU;
                        default:   next_state = EMIT;
                    endcase
                end
            end

            WB_LOAD: begin
                dp_mux_sel  = 1'b0;
                dp_load     = rst_n;
                dp_mux_data = imm_q;
                next_state  = IDLE;
            end

            WB_ALU: begin
                dp_mux_sel  = 1'b1;
                dp_load     = rst_n;
                dp_alu_sel  = alu_sel_q;
                dp_alu_data = imm_q;
                if (remaining == '0) begin
                    next_state = IDLE;
                end
            end

            EMIT: begin
                bus.res_valid = rst_n;
                if (bus.res_ready) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand latches and the iteration counter. The counter holds the
    // number of writebacks still to come after the current one, so a
    // REPEAT with cnt = 2^CNT_W-1 counts down to zero without ever wrapping.
    // EXEC loads zero here, which is why its cnt field has no effect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_sel_q <= 2'b00;
            imm_q     <= '0;
            remaining <= '0;
        end else if (accept) begin
            alu_sel_q <= in_alu_sel;
            imm_q     <= in_imm;
            remaining <= (in_op == OP_REPEAT) ? in_cnt : '0;
        end else if (state == WB_ALU && remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Carry flag follows the most recent writeback: a LOAD clears it and
    // every ALU writeback replaces it with that cycle's carry out, so it
    // reflects only the last operation rather than accumulating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_flag <= 1'b0;
        end else if (state == WB_LOAD) begin
            carry_flag <= 1'b0;
        end else if (state == WB_ALU) begin
            carry_flag <= dp_carry;
        end
    end

    // Result capture happens on the edge that accepts a READ, so the values
    // are frozen for the whole of EMIT regardless of how long the consumer
    // stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
        end else if (accept && in_op == OP_READ) begin
            res_data_q  <= dp_reg_out;
            res_carry_q <= carry_flag;
        end
    end

    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;

endmodule
